// File: rtl/cnn_pkg.sv
// Shared fixed-point types, FSM encoding and round/saturate helper for the CNN engines.
package cnn_pkg;

  localparam int WIDTH = 16;
  localparam int ACC_W = 40;

  typedef logic signed [WIDTH-1:0] fx_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {IDLE, ACC, ROUND, HOLD, DONE} pw_state_t;

  localparam fx_t  FX_MAX   = fx_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam fx_t  FX_MIN   = fx_t'({1'b1, {(WIDTH-1){1'b0}}});
  localparam acc_t FX_MAX_A = acc_t'(FX_MAX);
  localparam acc_t FX_MIN_A = acc_t'(FX_MIN);

  // Half-up rounding by 'frac' bits, optional ReLU, then clamp into the fx_t range.
  function automatic fx_t sat_round(acc_t a, int frac, bit relu);
    acc_t r;
    r = (a + (acc_t'(1) <<< (frac - 1))) >>> frac;
    if (relu && (r < 0)) r = '0;
    if (r > FX_MAX_A) return FX_MAX;
    if (r < FX_MIN_A) return FX_MIN;
    return fx_t'(r);
  endfunction

endpackage

// File: rtl/pw_mac_lane.sv
// One MAC lane: signed multiply, accumulate (load on the first channel),
// then bias/round/ReLU/saturate into a registered output.
// ACC_W may not exceed cnn_pkg::ACC_W and WIDTH must equal cnn_pkg::WIDTH,
// since rounding goes through the shared helper.
module pw_mac_lane
  import cnn_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ACC_W   = 40,
  parameter int FRAC    = 14,
  parameter int RELU_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      beat_i,
  input  logic                      first_i,
  input  logic                      round_i,
  input  logic signed [WIDTH-1:0]   ifm_i,
  input  logic signed [WIDTH-1:0]   ker_i,
  input  logic signed [2*WIDTH-1:0] bias_i,
  output logic signed [WIDTH-1:0]   ofm_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q, acc_d, sum;
  logic signed [WIDTH-1:0]   ofm_q, ofm_d;

  // Full-precision product, accumulation and the biased sum fed to rounding.
  always_comb begin
    prod  = ifm_i * ker_i;
    acc_d = acc_q;
    if (beat_i) acc_d = first_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    sum   = acc_q + ACC_W'(bias_i);
    ofm_d = ofm_q;
    if (round_i) ofm_d = sat_round(acc_t'(sum), FRAC, RELU_EN != 0);
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      ofm_q <= '0;
    end else begin
      acc_q <= acc_d;
      ofm_q <= ofm_d;
    end
  end

  assign ofm_o = ofm_q;

endmodule

// File: rtl/pw_conv_engine.sv
// Pointwise (1x1) convolution engine: DSP_NO parallel lanes, loops over
// CHOUT/DSP_NO output-channel groups and NPIX pixels per group.
module pw_conv_engine
  import cnn_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 14,
  parameter int ACC_W   = 40,
  parameter int DSP_NO  = 16,
  parameter int CHIN    = 128,
  parameter int CHOUT   = 16,
  parameter int NPIX    = 4096,
  parameter int RELU_EN = 1,
  localparam int G      = CHOUT / DSP_NO,
  localparam int GW     = (G > 1) ? $clog2(G) : 1,
  localparam int CW     = (CHIN > 1) ? $clog2(CHIN) : 1,
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int KAW    = (G * CHIN > 1) ? $clog2(G * CHIN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       ifm_valid_i,
  output logic                       ifm_ready_o,
  input  logic [WIDTH-1:0]           ifm_i,
  output logic [KAW-1:0]             ker_addr_o,
  input  logic [DSP_NO*WIDTH-1:0]    ker_data_i,
  output logic [GW-1:0]              bias_addr_o,
  input  logic [DSP_NO*2*WIDTH-1:0]  bias_data_i,
  output logic                       ofm_valid_o,
  input  logic                       ofm_ready_i,
  output logic [DSP_NO*WIDTH-1:0]    ofm_o,
  output logic [GW-1:0]              grp_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  pw_state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [GW-1:0] grp_q, grp_d;

  logic beat, hs, last_ch, last_pix, last_grp;
  logic [DSP_NO-1:0][WIDTH-1:0] ofm_lane;

  assign beat     = ifm_valid_i && ifm_ready_o;
  assign hs       = ofm_valid_o && ofm_ready_i;
  assign last_ch  = (ch_q  == CW'(CHIN - 1));
  assign last_pix = (pix_q == PW'(NPIX - 1));
  assign last_grp = (grp_q == GW'(G - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = ACC;
      ACC:     if (beat && last_ch) state_d = ROUND;
      ROUND:   state_d = HOLD;
      HOLD:    if (ofm_ready_i) state_d = (last_pix && last_grp) ? DONE : ACC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    ifm_ready_o = (state_q == ACC);
    ofm_valid_o = (state_q == HOLD);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
  end

  // Channel / pixel / group counters; all wrap back to zero at the end of a layer.
  always_comb begin
    ch_d  = ch_q;
    pix_d = pix_q;
    grp_d = grp_q;
    if (state_q == IDLE && start_i) begin
      ch_d  = '0;
      pix_d = '0;
      grp_d = '0;
    end
    if (beat) ch_d = last_ch ? '0 : ch_q + 1'b1;
    if (hs) begin
      if (last_pix) begin
        pix_d = '0;
        grp_d = last_grp ? '0 : grp_q + 1'b1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q  <= '0;
      pix_q <= '0;
      grp_q <= '0;
    end else begin
      ch_q  <= ch_d;
      pix_q <= pix_d;
      grp_q <= grp_d;
    end
  end

  assign ker_addr_o  = KAW'(int'(grp_q) * CHIN + int'(ch_q));
  assign bias_addr_o = grp_q;
  assign grp_idx_o   = grp_q;

  for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
    pw_mac_lane #(
      .WIDTH  (WIDTH),
      .ACC_W  (ACC_W),
      .FRAC   (FRAC),
      .RELU_EN(RELU_EN)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .beat_i (beat),
      .first_i(ch_q == '0),
      .round_i(state_q == ROUND),
      .ifm_i  (ifm_i),
      .ker_i  (ker_data_i[i*WIDTH +: WIDTH]),
      .bias_i (bias_data_i[i*2*WIDTH +: 2*WIDTH]),
      .ofm_o  (ofm_lane[i])
    );
  end

  assign ofm_o = ofm_lane;

endmodule

// File: tb/tb_pw_conv_engine.sv
// Directed bench for pw_conv_engine: small config, one ReLU and one linear instance on shared stimulus.
module tb_pw_conv_engine;

  localparam int W = 16, DN = 2, CHIN = 4, CHOUT = 4, NPIX = 2, FRAC = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0, ifm_valid_i = 1'b0, ofm_ready_i = 1'b0;
  logic [W-1:0] ifm_i = '0;
  logic signed [W-1:0] wt0 = '0, wt1 = '0;
  logic signed [2*W-1:0] bs0 = '0, bs1 = '0;
  logic [DN*W-1:0] ker_data;
  logic [DN*2*W-1:0] bias_data;

  logic r_ifm_ready, r_ofm_valid, r_busy, r_done;
  logic l_ifm_ready, l_ofm_valid, l_busy, l_done;
  logic [2:0] r_ker_addr, l_ker_addr;
  logic [0:0] r_bias_addr, l_bias_addr, r_grp, l_grp;
  logic [DN*W-1:0] r_ofm, l_ofm;

  int tests = 0, fails = 0;
  int vec[4];

  always #5 clk = ~clk;

  // Weight/bias ROMs are uniform across addresses; lane-specific only.
  always_comb begin
    ker_data  = {wt1, wt0};
    bias_data = {bs1, bs0};
  end

  pw_conv_engine #(.WIDTH(W), .FRAC(FRAC), .ACC_W(40), .DSP_NO(DN), .CHIN(CHIN),
                   .CHOUT(CHOUT), .NPIX(NPIX), .RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .start_i(start_i), .ifm_valid_i(ifm_valid_i),
    .ifm_ready_o(r_ifm_ready), .ifm_i(ifm_i), .ker_addr_o(r_ker_addr),
    .ker_data_i(ker_data), .bias_addr_o(r_bias_addr), .bias_data_i(bias_data),
    .ofm_valid_o(r_ofm_valid), .ofm_ready_i(ofm_ready_i), .ofm_o(r_ofm),
    .grp_idx_o(r_grp), .busy_o(r_busy), .done_o(r_done));

  pw_conv_engine #(.WIDTH(W), .FRAC(FRAC), .ACC_W(40), .DSP_NO(DN), .CHIN(CHIN),
                   .CHOUT(CHOUT), .NPIX(NPIX), .RELU_EN(0)) u_lin (
    .clk(clk), .rst(rst), .start_i(start_i), .ifm_valid_i(ifm_valid_i),
    .ifm_ready_o(l_ifm_ready), .ifm_i(ifm_i), .ker_addr_o(l_ker_addr),
    .ker_data_i(ker_data), .bias_addr_o(l_bias_addr), .bias_data_i(bias_data),
    .ofm_valid_o(l_ofm_valid), .ofm_ready_i(ofm_ready_i), .ofm_o(l_ofm),
    .grp_idx_o(l_grp), .busy_o(l_busy), .done_o(l_done));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ln(input logic [DN*W-1:0] o, input int i);
    logic signed [W-1:0] v;
    v = o[i*W +: W];
    return int'(v);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ifm_ready"}, int'(r_ifm_ready) + int'(l_ifm_ready), 0);
    chk({tag, "_ofm_valid"}, int'(r_ofm_valid) + int'(l_ofm_valid), 0);
    chk({tag, "_ofm"},       int'(r_ofm) + int'(l_ofm), 0);
    chk({tag, "_busy"},      int'(r_busy) + int'(l_busy), 0);
    chk({tag, "_done"},      int'(r_done) + int'(l_done), 0);
    chk({tag, "_grp"},       int'(r_grp) + int'(l_grp), 0);
  endtask

  // Stream vec[0..3] as one pixel; optional random ifm_valid gaps before each word.
  task automatic send_pixel(input int g, input bit gaps);
    int t;
    for (int c = 0; c < CHIN; c++) begin
      if (gaps) begin
        ifm_valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      ifm_valid_i = 1'b1;
      ifm_i = W'(vec[c]);
      t = 0;
      while (!r_ifm_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("ifm_ready_timeout", 0, 1);
      chk("ker_addr", int'(r_ker_addr), g * CHIN + c);
      @(posedge clk);
      @(negedge clk);
    end
    ifm_valid_i = 1'b0;
  endtask

  task automatic take_ofm(input string tag, input int g, input int e0r, input int e1r,
                          input int e0l, input int e1l, input bit last, input bit bp);
    int t, bad;
    logic [DN*W-1:0] keep;
    t = 0;
    while (!r_ofm_valid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ofm_valid_timeout", 0, 1);
    chk({tag, "_relu_l0"}, ln(r_ofm, 0), e0r);
    chk({tag, "_relu_l1"}, ln(r_ofm, 1), e1r);
    chk({tag, "_lin_l0"},  ln(l_ofm, 0), e0l);
    chk({tag, "_lin_l1"},  ln(l_ofm, 1), e1l);
    chk({tag, "_grp"},     int'(r_grp) * 2 + int'(l_grp), g * 3);
    chk({tag, "_bias_addr"}, int'(r_bias_addr), g);
    if (bp) begin
      keep = r_ofm;
      bad = 0;
      ifm_valid_i = 1'b1;
      ifm_i = 16'h7fff;
      start_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (!r_ofm_valid || !l_ofm_valid || r_ofm !== keep || r_ifm_ready || l_ifm_ready) bad++;
      end
      chk("bp_stable", bad, 0);
      ifm_valid_i = 1'b0;
    end
    ofm_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ofm_ready_i = 1'b0;
    chk({tag, "_single_hs"}, int'(r_ofm_valid), 0);
    if (last) begin
      chk("done_pulse", int'(r_done) + int'(l_done), 2);
      chk("busy_in_done", int'(r_busy), 1);
      @(negedge clk);
      chk("done_clear", int'(r_done) + int'(l_done), 0);
      chk("busy_fall", int'(r_busy) + int'(l_busy), 0);
    end else begin
      chk({tag, "_no_done"}, int'(r_done), 0);
    end
  endtask

  task automatic run_layer(input string tag, input int e0r, input int e1r,
                           input int e0l, input int e1l, input bit gaps, input bit bp);
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    chk({tag, "_busy"}, int'(r_busy), 1);
    for (int g = 0; g < CHOUT / DN; g++) begin
      for (int p = 0; p < NPIX; p++) begin
        send_pixel(g, gaps);
        chk({tag, "_lat_round"}, int'(r_ofm_valid), 0);
        @(negedge clk);
        chk({tag, "_lat_hold"}, int'(r_ofm_valid), 1);
        take_ofm(tag, g, e0r, e1r, e0l, e1l, (g == 1 && p == 1), bp && g == 0 && p == 0);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1.0 * 0.5 * 4 = 2.0 saturates positive; negative lane saturates / clamps
    vec = '{16384, 16384, 16384, 16384};
    wt0 = 16'sd8192; wt1 = 16'sd8192; bs0 = 0; bs1 = 0;
    run_layer("t1_possat", 32767, 32767, 32767, 32767, 1'b0, 1'b0);
    wt1 = -16'sd8192;
    run_layer("t1_negsat", 32767, 0, 32767, -32768, 1'b0, 1'b0);

    // 0.25 inputs, +0.25 / -0.5 weights, bias 0.125; includes backpressure
    vec = '{4096, 4096, 4096, 4096};
    wt0 = 16'sd4096; wt1 = -16'sd8192; bs0 = 32'sd33554432; bs1 = 32'sd33554432;
    run_layer("t2_bias", 6144, 0, 6144, -6144, 1'b0, 1'b1);

    // Rounding: 1.5 LSB -> 2, -0.5 LSB -> 0
    vec = '{1, 0, 0, 0};
    wt0 = 16'sd24576; wt1 = -16'sd8192; bs0 = 0; bs1 = 0;
    run_layer("t3_round", 2, 0, 2, 0, 1'b0, 1'b0);
    // 0.5 LSB -> 1, -1.5 LSB -> -1
    wt0 = 16'sd8192; wt1 = -16'sd24576;
    run_layer("t3_round_b", 1, 0, 1, -1, 1'b0, 1'b0);

    // Random ifm_valid gaps give the same results as the gap-free run
    vec = '{4096, 4096, 4096, 4096};
    wt0 = 16'sd4096; wt1 = -16'sd8192; bs0 = 32'sd33554432; bs1 = 32'sd33554432;
    run_layer("t5_gaps", 6144, 0, 6144, -6144, 1'b1, 1'b0);

    // Reset after two beats of a pixel, then a fresh layer
    vec = '{16384, 16384, 16384, 16384};
    wt0 = 16'sd8192; wt1 = 16'sd8192; bs0 = 0; bs1 = 0;
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    ifm_valid_i = 1'b1;
    ifm_i = 16'd16384;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    ifm_valid_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk_reset("post_rst");
    run_layer("t6_fresh", 32767, 32767, 32767, 32767, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
